// File: rtl/eth_tx_sched.sv
// Control-frame scheduler ahead of the Ethernet TX path: holds one pending ARP reply, ICMP echo
// reply and ARP request job each and issues them one frame at a time with an enforced gap.
module eth_tx_sched #(
    parameter int IFG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        arp_rep_req,
    input  logic [47:0] arp_rep_mac,
    input  logic [31:0] arp_rep_ip,
    input  logic        icmp_rep_req,
    input  logic [47:0] icmp_rep_mac,
    input  logic [31:0] icmp_rep_ip,
    input  logic [15:0] icmp_rep_id,
    input  logic [15:0] icmp_rep_seq,
    input  logic        arp_res_req,
    input  logic [31:0] arp_res_ip,
    input  logic        udp_frame_active,
    input  logic        arp_data_tx_done,
    input  logic        icmp_header_tx_done,
    output logic        eth_header_arp_tx_start,
    output logic        arp_oper,
    output logic        icmp_request_done,
    output logic [15:0] icmp_id,
    output logic [15:0] icmp_seq_num,
    output logic [47:0] mac_d_addr,
    output logic [31:0] ip_d_addr,
    output logic        busy,
    output logic        drop_pulse,
    output logic        timeout_pulse
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW = $clog2(IFG_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(IFG_CYCLES - 1);
    localparam logic [47:0]   BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_e;
    typedef enum logic {JOB_ARP, JOB_ICMP} job_e;

    state_e        state_q;
    job_e          job_q;
    logic [TW-1:0] to_cnt_q;
    logic [GW-1:0] gap_cnt_q;

    logic        rep_pend_q, icmp_pend_q, res_pend_q;
    logic [47:0] rep_mac_q, icmp_mac_q;
    logic [31:0] rep_ip_q, icmp_ip_q, res_ip_q;
    logic [15:0] slot_id_q, slot_seq_q;

    logic        arp_start_q, icmp_start_q, arp_oper_q, busy_q, drop_q, timeout_q;
    logic [15:0] icmp_id_q, icmp_seq_q;
    logic [47:0] mac_d_q;
    logic [31:0] ip_d_q;

    logic pick_ok, take_rep, take_icmp, take_res, done_hit, drop_d;

    // Arbitration only happens in IDLE, and never while a UDP frame owns the TX path.
    assign pick_ok   = (state_q == S_IDLE) && !udp_frame_active;
    assign take_rep  = pick_ok && rep_pend_q;
    assign take_icmp = pick_ok && !rep_pend_q && icmp_pend_q;
    assign take_res  = pick_ok && !rep_pend_q && !icmp_pend_q && res_pend_q;
    assign done_hit  = (job_q == JOB_ARP) ? arp_data_tx_done : icmp_header_tx_done;
    assign drop_d    = (arp_rep_req  && rep_pend_q  && !take_rep)
                     | (icmp_rep_req && icmp_pend_q && !take_icmp)
                     | (arp_res_req  && res_pend_q  && !take_res);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rep_pend_q  <= 1'b0;
            icmp_pend_q <= 1'b0;
            res_pend_q  <= 1'b0;
            rep_mac_q   <= '0;
            rep_ip_q    <= '0;
            icmp_mac_q  <= '0;
            icmp_ip_q   <= '0;
            slot_id_q   <= '0;
            slot_seq_q  <= '0;
            res_ip_q    <= '0;
            drop_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates mean the IDLE copy in the FSM block reads the slot
            // contents from before this edge, so a same-cycle re-arm never corrupts the frame.
            if (arp_rep_req) begin
                rep_pend_q <= 1'b1;
                rep_mac_q  <= arp_rep_mac;
                rep_ip_q   <= arp_rep_ip;
            end else if (take_rep) begin
                rep_pend_q <= 1'b0;
            end
            if (icmp_rep_req) begin
                icmp_pend_q <= 1'b1;
                icmp_mac_q  <= icmp_rep_mac;
                icmp_ip_q   <= icmp_rep_ip;
                slot_id_q   <= icmp_rep_id;
                slot_seq_q  <= icmp_rep_seq;
            end else if (take_icmp) begin
                icmp_pend_q <= 1'b0;
            end
            if (arp_res_req) begin
                res_pend_q <= 1'b1;
                res_ip_q   <= arp_res_ip;
            end else if (take_res) begin
                res_pend_q <= 1'b0;
            end
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            job_q        <= JOB_ARP;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            arp_start_q  <= 1'b0;
            icmp_start_q <= 1'b0;
            arp_oper_q   <= 1'b1;
            icmp_id_q    <= '0;
            icmp_seq_q   <= '0;
            mac_d_q      <= '0;
            ip_d_q       <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    to_cnt_q  <= '0;
                    gap_cnt_q <= '0;
                    if (take_rep) begin
                        job_q      <= JOB_ARP;
                        arp_oper_q <= 1'b1;
                        mac_d_q    <= rep_mac_q;
                        ip_d_q     <= rep_ip_q;
                    end else if (take_icmp) begin
                        job_q      <= JOB_ICMP;
                        mac_d_q    <= icmp_mac_q;
                        ip_d_q     <= icmp_ip_q;
                        icmp_id_q  <= slot_id_q;
                        icmp_seq_q <= slot_seq_q;
                    end else if (take_res) begin
                        job_q      <= JOB_ARP;
                        arp_oper_q <= 1'b0;
                        mac_d_q    <= BCAST_MAC;
                        ip_d_q     <= res_ip_q;
                    end
                    if (take_rep || take_icmp || take_res) begin
                        state_q      <= S_START;
                        busy_q       <= 1'b1;
                        arp_start_q  <= !take_icmp;
                        icmp_start_q <= take_icmp;
                    end
                end
                S_START: begin
                    arp_start_q  <= 1'b0;
                    icmp_start_q <= 1'b0;
                    to_cnt_q     <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                    if (done_hit) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_GAP;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt_q <= gap_cnt_q + GW'(1);
                    if (gap_cnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign eth_header_arp_tx_start = arp_start_q;
    assign icmp_request_done       = icmp_start_q;
    assign arp_oper                = arp_oper_q;
    assign icmp_id                 = icmp_id_q;
    assign icmp_seq_num            = icmp_seq_q;
    assign mac_d_addr              = mac_d_q;
    assign ip_d_addr               = ip_d_q;
    assign busy                    = busy_q;
    assign drop_pulse              = drop_q;
    assign timeout_pulse           = timeout_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: directed corner sequences, a priority vector table,
// and a randomized run against a cycle-arithmetic reference model of the scheduling rules.
module tb_eth_tx_sched;
    localparam int IFG = 16;
    localparam int TMO = 4096;
    localparam logic [47:0] REP_MAC  = 48'h02_11_22_33_44_55;
    localparam logic [31:0] REP_IP   = 32'hC0A8_010A;
    localparam logic [47:0] ICMP_MAC = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [31:0] ICMP_IP  = 32'hC0A8_0114;
    localparam logic [15:0] ICMP_ID  = 16'h1234;
    localparam logic [15:0] ICMP_SEQ = 16'd7;
    localparam logic [31:0] RES_IP   = 32'hC0A8_0101;
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

    logic aclk, aresetn;
    logic arp_rep_req, icmp_rep_req, arp_res_req;
    logic [47:0] arp_rep_mac, icmp_rep_mac;
    logic [31:0] arp_rep_ip, icmp_rep_ip, arp_res_ip;
    logic [15:0] icmp_rep_id, icmp_rep_seq;
    logic udp_frame_active, arp_data_tx_done, icmp_header_tx_done;
    logic eth_header_arp_tx_start, arp_oper, icmp_request_done;
    logic [15:0] icmp_id, icmp_seq_num;
    logic [47:0] mac_d_addr;
    logic [31:0] ip_d_addr;
    logic busy, drop_pulse, timeout_pulse;

    eth_tx_sched #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arp_rep_req(arp_rep_req), .arp_rep_mac(arp_rep_mac), .arp_rep_ip(arp_rep_ip),
        .icmp_rep_req(icmp_rep_req), .icmp_rep_mac(icmp_rep_mac), .icmp_rep_ip(icmp_rep_ip),
        .icmp_rep_id(icmp_rep_id), .icmp_rep_seq(icmp_rep_seq),
        .arp_res_req(arp_res_req), .arp_res_ip(arp_res_ip),
        .udp_frame_active(udp_frame_active), .arp_data_tx_done(arp_data_tx_done),
        .icmp_header_tx_done(icmp_header_tx_done),
        .eth_header_arp_tx_start(eth_header_arp_tx_start), .arp_oper(arp_oper),
        .icmp_request_done(icmp_request_done), .icmp_id(icmp_id), .icmp_seq_num(icmp_seq_num),
        .mac_d_addr(mac_d_addr), .ip_d_addr(ip_d_addr), .busy(busy),
        .drop_pulse(drop_pulse), .timeout_pulse(timeout_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        arp;
        logic        icmp;
        logic        oper;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] id;
        logic [15:0] seq;
    } frame_t;

    typedef struct {
        bit rep;
        bit icmp;
        bit res;
        int n;
        int o0;
        int o1;
        int o2;
    } prio_vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ts, td, tto, n, nstart, ndrop, j, last_done;
    logic oper_now;
    frame_t ef;
    prio_vec_t pv[5];

    // Random-phase reference model state
    bit          m_pend[3];
    logic [47:0] s_mac[3];
    logic [31:0] s_ip[3];
    logic [15:0] s_id, s_seq;
    bit          m_fr, m_to, m_drop, udp_lvl, exp_strobe;
    int          m_start, m_job, m_done, m_resp;
    logic        e_oper;
    logic [47:0] e_mac;
    logic [31:0] e_ip;
    logic [15:0] e_id, e_seq;
    logic [4:0]  exp_ctl;
    logic [63:0] tmp64;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic pulses_low();
        arp_rep_req = 1'b0;
        icmp_rep_req = 1'b0;
        arp_res_req = 1'b0;
        arp_data_tx_done = 1'b0;
        icmp_header_tx_done = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        pulses_low();
        udp_frame_active = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic set_rep(input logic [47:0] mac, input logic [31:0] ip);
        arp_rep_req = 1'b1; arp_rep_mac = mac; arp_rep_ip = ip;
    endtask

    task automatic set_icmp(input logic [47:0] mac, input logic [31:0] ip,
                            input logic [15:0] id, input logic [15:0] seq);
        icmp_rep_req = 1'b1; icmp_rep_mac = mac; icmp_rep_ip = ip;
        icmp_rep_id = id; icmp_rep_seq = seq;
    endtask

    task automatic set_res(input logic [31:0] ip);
        arp_res_req = 1'b1; arp_res_ip = ip;
    endtask

    function automatic frame_t job_frame(input int jj, input logic prev_oper);
        frame_t f;
        f.arp  = (jj != 1);
        f.icmp = (jj == 1);
        f.oper = (jj == 0) ? 1'b1 : (jj == 2) ? 1'b0 : prev_oper;
        f.mac  = (jj == 0) ? REP_MAC : (jj == 1) ? ICMP_MAC : BCAST;
        f.ip   = (jj == 0) ? REP_IP : (jj == 1) ? ICMP_IP : RES_IP;
        f.id   = ICMP_ID;
        f.seq  = ICMP_SEQ;
        return f;
    endfunction

    // Waits (bounded) for a start pulse and compares the issued frame against f.
    task automatic expect_frame(input string name, input frame_t f, input int budget,
                                output int t_start);
        int k = 0;
        while (!(eth_header_arp_tx_start || icmp_request_done) && k < budget) begin
            tick();
            k++;
        end
        check({name, " start seen"}, 128'(eth_header_arp_tx_start | icmp_request_done), 128'(1));
        check({name, " type"}, 128'({eth_header_arp_tx_start, icmp_request_done}),
              128'({f.arp, f.icmp}));
        check({name, " oper"}, 128'(arp_oper), 128'(f.oper));
        check({name, " mac"}, 128'(mac_d_addr), 128'(f.mac));
        check({name, " ip"}, 128'(ip_d_addr), 128'(f.ip));
        if (f.icmp) check({name, " id/seq"}, 128'({icmp_id, icmp_seq_num}), 128'({f.id, f.seq}));
        t_start = cyc;
    endtask

    task automatic respond(input logic is_icmp, input int after, output int t_done);
        repeat (after) tick();
        if (is_icmp) icmp_header_tx_done = 1'b1;
        else arp_data_tx_done = 1'b1;
        t_done = cyc;
        tick();
        arp_data_tx_done = 1'b0;
        icmp_header_tx_done = 1'b0;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pv[0] = '{1, 1, 1, 3, 0, 1, 2};
        pv[1] = '{0, 1, 1, 2, 1, 2, 0};
        pv[2] = '{1, 0, 1, 2, 0, 2, 0};
        pv[3] = '{1, 1, 0, 2, 0, 1, 0};
        pv[4] = '{0, 0, 1, 1, 2, 0, 0};
        arp_rep_mac = '0; arp_rep_ip = '0; icmp_rep_mac = '0; icmp_rep_ip = '0;
        icmp_rep_id = '0; icmp_rep_seq = '0; arp_res_ip = '0;

        // Reset state
        do_reset();
        check("reset ctl", 128'({eth_header_arp_tx_start, icmp_request_done, busy, drop_pulse,
                                 timeout_pulse, arp_oper}), 128'(6'b000001));
        check("reset fields", 128'({mac_d_addr, ip_d_addr, icmp_id, icmp_seq_num}), 128'(0));

        // Single ARP reply: start 2 cycles after request, busy drops 17 cycles after done
        set_rep(REP_MAC, REP_IP);
        ts = cyc;
        tick();
        pulses_low();
        check("arp1 no early start", 128'(eth_header_arp_tx_start), 128'(0));
        tick();
        check("arp1 start latency", 128'(eth_header_arp_tx_start), 128'(1));
        check("arp1 fields", 128'({arp_oper, mac_d_addr, ip_d_addr, busy}),
              128'({1'b1, REP_MAC, REP_IP, 1'b1}));
        tick();
        check("arp1 start one cycle", 128'(eth_header_arp_tx_start), 128'(0));
        repeat (39) tick();
        arp_data_tx_done = 1'b1;
        td = cyc;
        tick();
        arp_data_tx_done = 1'b0;
        check("arp1 fields held", 128'({mac_d_addr, ip_d_addr}), 128'({REP_MAC, REP_IP}));
        repeat (15) tick();
        check("arp1 busy at done+16", 128'(busy), 128'(1));
        tick();
        check("arp1 busy at done+17", 128'({busy, 32'(cyc - td)}), 128'({1'b0, 32'd17}));

        // Priority table: requests raised together, frames come out in priority order
        for (int v = 0; v < 5; v++) begin
            do_reset();
            oper_now = 1'b1;
            if (pv[v].rep) set_rep(REP_MAC, REP_IP);
            if (pv[v].icmp) set_icmp(ICMP_MAC, ICMP_IP, ICMP_ID, ICMP_SEQ);
            if (pv[v].res) set_res(RES_IP);
            tick();
            pulses_low();
            last_done = 0;
            for (int k = 0; k < pv[v].n; k++) begin
                j = (k == 0) ? pv[v].o0 : (k == 1) ? pv[v].o1 : pv[v].o2;
                ef = job_frame(j, oper_now);
                oper_now = ef.oper;
                expect_frame($sformatf("prio%0d.%0d", v, k), ef, 100, ts);
                if (k > 0)
                    check($sformatf("prio%0d.%0d gap", v, k), 128'((ts - last_done) >= IFG + 1),
                          128'(1));
                respond(ef.icmp, 3, last_done);
            end
        end

        // Overwrite: two ICMP requests while ARP frame is in WAIT -> one drop, seq 2 sent
        do_reset();
        set_rep(REP_MAC, REP_IP);
        tick();
        pulses_low();
        expect_frame("ovr arp", job_frame(0, 1'b1), 10, ts);
        repeat (2) tick();
        ndrop = 0;
        set_icmp(ICMP_MAC, ICMP_IP, ICMP_ID, 16'd1);
        tick();
        icmp_rep_req = 1'b0;
        ndrop += int'(drop_pulse);
        repeat (2) begin tick(); ndrop += int'(drop_pulse); end
        set_icmp(ICMP_MAC, ICMP_IP, ICMP_ID, 16'd2);
        tick();
        icmp_rep_req = 1'b0;
        check("ovr drop timing", 128'(drop_pulse), 128'(1));
        ndrop += int'(drop_pulse);
        repeat (3) begin tick(); ndrop += int'(drop_pulse); end
        check("ovr drop count", 128'(ndrop), 128'(1));
        respond(1'b0, 0, td);
        ef = job_frame(1, 1'b1);
        ef.seq = 16'd2;
        expect_frame("ovr icmp", ef, 40, ts);
        respond(1'b1, 2, td);

        // UDP hold-off: pending ARP reply waits until udp_frame_active falls
        do_reset();
        udp_frame_active = 1'b1;
        set_rep(REP_MAC, REP_IP);
        tick();
        pulses_low();
        nstart = 0;
        repeat (20) begin tick(); nstart += int'(eth_header_arp_tx_start | icmp_request_done); end
        check("udp hold no start", 128'(nstart), 128'(0));
        udp_frame_active = 1'b0;
        tick();
        check("udp release start", 128'(eth_header_arp_tx_start), 128'(1));
        respond(1'b0, 4, td);

        // Timeout: ICMP job never completes; stray ARP done in WAIT is ignored
        do_reset();
        set_icmp(ICMP_MAC, ICMP_IP, ICMP_ID, ICMP_SEQ);
        tick();
        pulses_low();
        expect_frame("tmo icmp", job_frame(1, 1'b1), 10, ts);
        repeat (9) tick();
        arp_data_tx_done = 1'b1;
        tick();
        arp_data_tx_done = 1'b0;
        check("tmo stray ignored", 128'({busy, timeout_pulse}), 128'(2'b10));
        n = 0;
        while (!timeout_pulse && n < TMO + 100) begin tick(); n++; end
        tto = cyc;
        check("tmo latency", 128'(timeout_pulse ? (tto - ts) : -1), 128'(TMO + 1));
        check("tmo busy at pulse", 128'(busy), 128'(1));
        tick();
        check("tmo pulse one cycle", 128'(timeout_pulse), 128'(0));
        repeat (14) tick();
        check("tmo gap busy", 128'(busy), 128'(1));
        tick();
        check("tmo idle after gap", 128'(busy), 128'(0));

        // Async reset mid-frame: outputs clear at once, pending jobs are lost
        do_reset();
        set_rep(REP_MAC, REP_IP);
        set_icmp(ICMP_MAC, ICMP_IP, ICMP_ID, ICMP_SEQ);
        set_res(RES_IP);
        tick();
        pulses_low();
        expect_frame("rst arp", job_frame(0, 1'b1), 10, ts);
        repeat (5) tick();
        #2 aresetn = 1'b0;
        #1;
        check("rst async ctl", 128'({eth_header_arp_tx_start, icmp_request_done, busy,
                                     arp_oper}), 128'(4'b0001));
        check("rst async fields", 128'({mac_d_addr, ip_d_addr}), 128'(0));
        repeat (2) tick();
        aresetn = 1'b1;
        nstart = 0;
        repeat (60) begin tick(); nstart += int'(eth_header_arp_tx_start | icmp_request_done); end
        check("rst no stale frame", 128'(nstart), 128'(0));
        set_res(RES_IP);
        tick();
        pulses_low();
        expect_frame("rst new req", job_frame(2, 1'b1), 10, ts);

        // Randomized run against the reference model
        do_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 1'b0; s_mac[k] = '0; s_ip[k] = '0;
        end
        s_id = '0; s_seq = '0;
        m_fr = 1'b0; m_to = 1'b0; m_drop = 1'b0; udp_lvl = 1'b0;
        m_start = 0; m_job = 0; m_done = -1; m_resp = 0;
        e_oper = 1'b1; e_mac = '0; e_ip = '0; e_id = '0; e_seq = '0;
        for (int c = 0; c < 3000; c++) begin
            if (m_fr && m_done >= 0 && c > m_done + IFG) m_fr = 1'b0;
            exp_ctl = {m_fr && c == m_start && m_job != 1, m_fr && c == m_start && m_job == 1,
                       m_fr, m_drop, m_fr && m_to && c == m_done + 1};
            check("rnd ctl", 128'({eth_header_arp_tx_start, icmp_request_done, busy, drop_pulse,
                                   timeout_pulse}), 128'(exp_ctl));
            check("rnd fields", {15'd0, arp_oper, mac_d_addr, ip_d_addr, icmp_id, icmp_seq_num},
                  {15'd0, e_oper, e_mac, e_ip, e_id, e_seq});

            arp_rep_req  = ($urandom_range(0, 24) == 0);
            icmp_rep_req = ($urandom_range(0, 24) == 0);
            arp_res_req  = ($urandom_range(0, 24) == 0);
            tmp64 = {$urandom(), $urandom()};
            arp_rep_mac = tmp64[47:0];
            tmp64 = {$urandom(), $urandom()};
            icmp_rep_mac = tmp64[47:0];
            arp_rep_ip = $urandom(); icmp_rep_ip = $urandom(); arp_res_ip = $urandom();
            tmp64 = {$urandom(), $urandom()};
            icmp_rep_id = tmp64[15:0];
            icmp_rep_seq = tmp64[31:16];
            if ($urandom_range(0, 39) == 0) udp_lvl = !udp_lvl;
            udp_frame_active = udp_lvl;
            arp_data_tx_done = 1'b0;
            icmp_header_tx_done = 1'b0;
            if (m_fr && m_done < 0 && c > m_start) begin
                if (c == m_resp) begin
                    if (m_job == 1) icmp_header_tx_done = 1'b1;
                    else arp_data_tx_done = 1'b1;
                end else if ($urandom_range(0, 19) == 0) begin
                    if (m_job == 1) arp_data_tx_done = 1'b1;
                    else icmp_header_tx_done = 1'b1;
                end
            end

            if (m_fr && m_done < 0 && c > m_start) begin
                exp_strobe = (m_job == 1) ? icmp_header_tx_done : arp_data_tx_done;
                if (exp_strobe) begin m_done = c; m_to = 1'b0; end
                else if (c == m_start + TMO) begin m_done = c; m_to = 1'b1; end
            end
            if (!m_fr && !udp_lvl && (m_pend[0] || m_pend[1] || m_pend[2])) begin
                j = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
                m_fr = 1'b1; m_start = c + 1; m_job = j; m_done = -1; m_to = 1'b0;
                m_pend[j] = 1'b0;
                e_mac = (j == 2) ? BCAST : s_mac[j];
                e_ip = s_ip[j];
                if (j == 0) e_oper = 1'b1;
                if (j == 2) e_oper = 1'b0;
                if (j == 1) begin e_id = s_id; e_seq = s_seq; end
                m_resp = c + 1 + int'($urandom_range(2, 50));
            end
            m_drop = 1'b0;
            if (arp_rep_req) begin
                if (m_pend[0]) m_drop = 1'b1;
                m_pend[0] = 1'b1; s_mac[0] = arp_rep_mac; s_ip[0] = arp_rep_ip;
            end
            if (icmp_rep_req) begin
                if (m_pend[1]) m_drop = 1'b1;
                m_pend[1] = 1'b1; s_mac[1] = icmp_rep_mac; s_ip[1] = icmp_rep_ip;
                s_id = icmp_rep_id; s_seq = icmp_rep_seq;
            end
            if (arp_res_req) begin
                if (m_pend[2]) m_drop = 1'b1;
                m_pend[2] = 1'b1; s_ip[2] = arp_res_ip;
            end
            tick();
        end
        pulses_low();
        udp_frame_active = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
